// File: rtl/kernel_bank.sv
// kernel_bank: ping-pong store of NUM_KERNELS conv kernels.
// Weights stream into the shadow bank; swap promotes it to active.
module kernel_bank #(
  parameter  int BITS        = 9,
  parameter  int KERNEL_SIZE = 3,
  parameter  int NUM_KERNELS = 4,
  localparam int KK = KERNEL_SIZE * KERNEL_SIZE,
  localparam int KW = (NUM_KERNELS > 1) ?
                      $clog2(NUM_KERNELS) : 1,
  localparam int PW = (KK > 1) ? $clog2(KK) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en,
  input  logic [BITS-1:0]  kernel_in,
  input  logic [KW-1:0]    wr_kernel,
  input  logic             swap,
  input  logic [KW-1:0]    rd_sel,
  output logic [KK*BITS-1:0] out,
  output logic             ready,
  output logic             shadow_full,
  output logic             busy,
  output logic             swap_ack
);

  typedef logic [BITS-1:0] elem_t;

  elem_t mem_q [2][NUM_KERNELS][KK];
  elem_t mem_d [2][NUM_KERNELS][KK];

  logic [NUM_KERNELS-1:0] valid_q, valid_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [KW-1:0]          cur_k_q, cur_k_d;
  logic                   bank_sel_q, bank_sel_d;
  logic                   ready_q, ready_d;
  logic                   swap_ack_q, swap_ack_d;
  logic [KK*BITS-1:0]     out_q, out_d;

  logic          accept;
  logic          wbank;
  logic [KW-1:0] k_eff;
  logic          k_ok;
  logic          rd_ok;
  logic          last_el;

  // A swap is only safe between kernels with a full shadow set.
  assign accept  = swap && (&valid_q) &&
                   (wr_ptr_q == '0);
  // In the accept cycle the old active bank becomes shadow.
  assign wbank   = accept ? bank_sel_q : ~bank_sel_q;
  assign k_eff   = (wr_ptr_q == '0) ? wr_kernel : cur_k_q;
  assign k_ok    = int'(k_eff) < NUM_KERNELS;
  assign rd_ok   = int'(rd_sel) < NUM_KERNELS;
  assign last_el = (wr_ptr_q == PW'(KK - 1));

  // Next-state: swap, shadow write and active-bank read.
  always_comb begin
    mem_d      = mem_q;
    valid_d    = valid_q;
    wr_ptr_d   = wr_ptr_q;
    cur_k_d    = cur_k_q;
    bank_sel_d = bank_sel_q;
    ready_d    = ready_q;
    swap_ack_d = 1'b0;
    out_d      = '0;

    if (accept) begin
      bank_sel_d = ~bank_sel_q;
      valid_d    = '0;
      ready_d    = 1'b1;
      swap_ack_d = 1'b1;
    end

    if (write_en) begin
      cur_k_d = k_eff;
      if (k_ok)
        mem_d[wbank][k_eff][wr_ptr_q] = kernel_in;
      if (last_el) begin
        wr_ptr_d = '0;
        if (k_ok)
          valid_d[k_eff] = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end

    if (rd_ok) begin
      for (int e = 0; e < KK; e++)
        out_d[(KK-e)*BITS-1 -: BITS] =
          mem_q[bank_sel_q][rd_sel][e];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < NUM_KERNELS; k++)
          for (int e = 0; e < KK; e++)
            mem_q[b][k][e] <= '0;
      valid_q    <= '0;
      wr_ptr_q   <= '0;
      cur_k_q    <= '0;
      bank_sel_q <= 1'b0;
      ready_q    <= 1'b0;
      swap_ack_q <= 1'b0;
      out_q      <= '0;
    end else begin
      mem_q      <= mem_d;
      valid_q    <= valid_d;
      wr_ptr_q   <= wr_ptr_d;
      cur_k_q    <= cur_k_d;
      bank_sel_q <= bank_sel_d;
      ready_q    <= ready_d;
      swap_ack_q <= swap_ack_d;
      out_q      <= out_d;
    end
  end

  assign out         = out_q;
  assign ready       = ready_q;
  assign swap_ack    = swap_ack_q;
  assign shadow_full = &valid_q;
  assign busy        = (wr_ptr_q != '0);

endmodule

// File: tb/tb_kernel_bank.sv
// tb_kernel_bank: directed scenarios for kernel_bank.
// Each task drives and checks one scenario.
module tb_kernel_bank;

  localparam int BITS = 9;
  localparam int KK   = 9;
  localparam int KW   = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               write_en = 1'b0;
  logic [BITS-1:0]    kernel_in = '0;
  logic [KW-1:0]      wr_kernel = '0;
  logic               swap = 1'b0;
  logic [KW-1:0]      rd_sel = '0;
  logic [KK*BITS-1:0] out;
  logic               ready;
  logic               shadow_full;
  logic               busy;
  logic               swap_ack;

  int tests = 0;
  int fails = 0;

  kernel_bank dut (
    .clk         (clk),
    .reset       (reset),
    .write_en    (write_en),
    .kernel_in   (kernel_in),
    .wr_kernel   (wr_kernel),
    .swap        (swap),
    .rd_sel      (rd_sel),
    .out         (out),
    .ready       (ready),
    .shadow_full (shadow_full),
    .busy        (busy),
    .swap_ack    (swap_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [KK*BITS-1:0] kvec(
    input int first
  );
    logic [KK*BITS-1:0] r;
    r = '0;
    for (int e = 0; e < KK; e++)
      r[(KK-e)*BITS-1 -: BITS] = BITS'(first + e);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(
    input int k, input int first, input int n
  );
    write_en  = 1'b1;
    wr_kernel = KW'(k);
    for (int e = 0; e < n; e++) begin
      kernel_in = BITS'(first + e);
      tick();
    end
    write_en = 1'b0;
  endtask

  task automatic load_set(input int base);
    for (int k = 0; k < 4; k++)
      write_n(k, base + k * 16, KK);
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (out !== '0) begin
      $display("FAIL reset_out got %h exp 0", out);
      fails++;
    end
    tests++;
    if (ready !== 1'b0) begin
      $display("FAIL reset_ready got %b exp 0", ready);
      fails++;
    end
    tests++;
    if (shadow_full !== 1'b0) begin
      $display("FAIL reset_full got %b exp 0",
               shadow_full);
      fails++;
    end
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_busy got %b exp 0", busy);
      fails++;
    end
    tests++;
    if (swap_ack !== 1'b0) begin
      $display("FAIL reset_ack got %b exp 0", swap_ack);
      fails++;
    end
  endtask

  task automatic test_load();
    rd_sel = 2'd2;
    load_set(1);
    tests++;
    if (shadow_full !== 1'b1) begin
      $display("FAIL load_full got %b exp 1",
               shadow_full);
      fails++;
    end
    tests++;
    if (ready !== 1'b0) begin
      $display("FAIL load_pre_ready got %b exp 0",
               ready);
      fails++;
    end
    do_swap();
    tests++;
    if (swap_ack !== 1'b1 || ready !== 1'b1) begin
      $display("FAIL load_ack got ack=%b rdy=%b exp 1 1",
               swap_ack, ready);
      fails++;
    end
    tests++;
    if (shadow_full !== 1'b0) begin
      $display("FAIL load_post_full got %b exp 0",
               shadow_full);
      fails++;
    end
    tick();
    tests++;
    if (swap_ack !== 1'b0) begin
      $display("FAIL load_ack_pulse got %b exp 0",
               swap_ack);
      fails++;
    end
    tests++;
    if (out !== kvec('h21)) begin
      $display("FAIL load_out got %h exp %h",
               out, kvec('h21));
      fails++;
    end
  endtask

  task automatic test_reject();
    for (int k = 0; k < 3; k++)
      write_n(k, 'h81 + k * 16, KK);
    do_swap();
    tests++;
    if (swap_ack !== 1'b0 || shadow_full !== 1'b0) begin
      $display("FAIL rej3_ack got ack=%b full=%b exp 0 0",
               swap_ack, shadow_full);
      fails++;
    end
    write_n(3, 'hB1, KK);
    write_n(0, 'hF0, 4);
    tests++;
    if (busy !== 1'b1 || shadow_full !== 1'b1) begin
      $display("FAIL rej_busy got busy=%b full=%b exp 1 1",
               busy, shadow_full);
      fails++;
    end
    do_swap();
    tests++;
    if (swap_ack !== 1'b0) begin
      $display("FAIL rej_busy_ack got %b exp 0",
               swap_ack);
      fails++;
    end
    tick();
    tests++;
    if (out !== kvec('h21)) begin
      $display("FAIL rej_out got %h exp %h",
               out, kvec('h21));
      fails++;
    end
    write_n(0, 'hF4, 5);
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL rej_done_busy got %b exp 0", busy);
      fails++;
    end
    rd_sel = 2'd0;
    do_swap();
    tests++;
    if (swap_ack !== 1'b1) begin
      $display("FAIL rej_final_ack got %b exp 1",
               swap_ack);
      fails++;
    end
    tick();
    tests++;
    if (out !== kvec('hF0)) begin
      $display("FAIL rej_slot0 got %h exp %h",
               out, kvec('hF0));
      fails++;
    end
  endtask

  task automatic test_simultaneous();
    load_set('h101);
    swap      = 1'b1;
    write_en  = 1'b1;
    wr_kernel = 2'd1;
    kernel_in = 9'h055;
    tick();
    swap     = 1'b0;
    write_en = 1'b0;
    tests++;
    if (swap_ack !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL sim_ack got ack=%b busy=%b exp 1 1",
               swap_ack, busy);
      fails++;
    end
    write_n(1, 'h56, 8);
    tests++;
    if (busy !== 1'b0 || shadow_full !== 1'b0) begin
      $display("FAIL sim_mid got busy=%b full=%b exp 0 0",
               busy, shadow_full);
      fails++;
    end
    rd_sel = 2'd3;
    tick();
    tests++;
    if (out !== kvec('h131)) begin
      $display("FAIL sim_active got %h exp %h",
               out, kvec('h131));
      fails++;
    end
    write_n(0, 'h1C1, KK);
    write_n(2, 'h1E1, KK);
    write_n(3, 'h1F1, KK);
    rd_sel = 2'd1;
    do_swap();
    tests++;
    if (swap_ack !== 1'b1) begin
      $display("FAIL sim_swap2 got %b exp 1", swap_ack);
      fails++;
    end
    tick();
    tests++;
    if (out !== kvec('h55)) begin
      $display("FAIL sim_out got %h exp %h",
               out, kvec('h55));
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    write_n(3, 'h33, 5);
    tests++;
    if (busy !== 1'b1) begin
      $display("FAIL mid_busy got %b exp 1", busy);
      fails++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      $display("FAIL mid_rst got busy=%b rdy=%b exp 0 0",
               busy, ready);
      fails++;
    end
    for (int s = 0; s < 4; s++) begin
      rd_sel = KW'(s);
      tick();
      tests++;
      if (out !== '0) begin
        $display("FAIL mid_zero%0d got %h exp 0", s, out);
        fails++;
      end
    end
    load_set('h11);
    rd_sel = 2'd3;
    do_swap();
    tests++;
    if (swap_ack !== 1'b1 || ready !== 1'b1) begin
      $display("FAIL mid_swap got ack=%b rdy=%b exp 1 1",
               swap_ack, ready);
      fails++;
    end
    tick();
    tests++;
    if (out !== kvec('h41)) begin
      $display("FAIL mid_out got %h exp %h",
               out, kvec('h41));
      fails++;
    end
  endtask

  task automatic test_pingpong();
    write_en = 1'b1;
    for (int i = 0; i < 4 * KK; i++) begin
      wr_kernel = KW'(i / KK);
      kernel_in = BITS'('h181 + (i / KK) * 16 + i % KK);
      rd_sel    = KW'(i % 4);
      tick();
      tests++;
      if (out !== kvec('h11 + (i % 4) * 16)) begin
        $display("FAIL pp_read%0d got %h exp %h", i, out,
                 kvec('h11 + (i % 4) * 16));
        fails++;
      end
    end
    write_en = 1'b0;
    rd_sel   = 2'd2;
    do_swap();
    tests++;
    if (swap_ack !== 1'b1) begin
      $display("FAIL pp_swap got %b exp 1", swap_ack);
      fails++;
    end
    tick();
    tests++;
    if (out !== kvec('h1A1)) begin
      $display("FAIL pp_new got %h exp %h",
               out, kvec('h1A1));
      fails++;
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_load();
    test_reject();
    test_simultaneous();
    test_reset_mid();
    test_pingpong();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
